// File: rtl/ym2149_seq_pkg.sv
// ym2149_seq_pkg: shared op encodings, FSM states and defaults
// for the YM2149 register-write sequencer.
package ym2149_seq_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_WAIT  = 2'b01,
        OP_HALT  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_RECOVER,
        ST_WAIT,
        ST_HALT
    } state_e;

    localparam int SAMPLE_DIV_DEF = 567;
    localparam int WR_HOLD_DEF    = 2;

endpackage

// File: rtl/ym2149_seq_if.sv
// ym2149_seq_if: command channel (valid/ready, op, arg).
// master drives commands, slave (sequencer) returns ready.
interface ym2149_seq_if;

    logic        in_cmd_valid;
    logic        out_cmd_ready;
    logic [1:0]  in_cmd_op;
    logic [15:0] in_cmd_arg;

    modport master (
        output in_cmd_valid,
        output in_cmd_op,
        output in_cmd_arg,
        input  out_cmd_ready
    );

    modport slave (
        input  in_cmd_valid,
        input  in_cmd_op,
        input  in_cmd_arg,
        output out_cmd_ready
    );

endinterface

// File: rtl/ym2149_seq_sample_tick_gen.sv
// sample_tick_gen: free-running sample divider.
// Ports: in_clk, in_rst, in_pause (hold), out_tick (1-cycle pulse).
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 567
) (
    input  logic in_clk,
    input  logic in_rst,
    input  logic in_pause,
    output logic out_tick
);

    localparam logic [15:0] RELOAD = 16'(SAMPLE_DIV - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_cnt <= RELOAD;
        end else if (!in_pause) begin
            if (r_cnt == 16'd0)
                r_cnt <= RELOAD;
            else
                r_cnt <= r_cnt - 16'd1;
        end
    end

    assign out_tick = (r_cnt == 16'd0) && !in_pause;

endmodule

// File: rtl/ym2149_seq.sv
// ym2149_seq: command sequencer driving PSG register writes,
// sample-tick WAITs and HALT. Ports: clk/rst, cmd (slave),
// in_pause, PSG bus out_reg/out_val/out_wr, out_tick, status.
module ym2149_seq
    import ym2149_seq_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int WR_HOLD    = WR_HOLD_DEF
) (
    input  logic               in_clk,
    input  logic               in_rst,
    ym2149_seq_if.slave        cmd,
    input  logic               in_pause,
    output logic [3:0]         out_reg,
    output logic [7:0]         out_val,
    output logic               out_wr,
    output logic               out_tick,
    output logic               out_busy,
    output logic               out_halted
);

    localparam logic [3:0] HOLD_LD = 4'(WR_HOLD - 1);

    state_e      r_state;
    state_e      w_next;
    logic [3:0]  r_reg;
    logic [7:0]  r_val;
    logic [3:0]  r_hold;
    logic [15:0] r_wait;
    logic        w_tick;
    logic        w_ready;
    logic        w_acc;
    op_e         w_op;

    sample_tick_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick (
        .in_clk   (in_clk),
        .in_rst   (in_rst),
        .in_pause (in_pause),
        .out_tick (w_tick)
    );

    assign w_op  = op_e'(cmd.in_cmd_op);
    assign w_acc = cmd.in_cmd_valid && w_ready;

    always_ff @(posedge in_clk) begin
        if (in_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    unique case (w_op)
                        OP_WRITE: w_next = ST_SETUP;
                        // WAIT 0 still spends one cycle in WAIT
                        OP_WAIT:  w_next = ST_WAIT;
                        OP_HALT:  w_next = ST_HALT;
                        OP_RSVD:  w_next = ST_IDLE;
                    endcase
                end
            end
            ST_SETUP:   w_next = ST_STROBE;
            ST_STROBE: begin
                if (r_hold == 4'd0)
                    w_next = ST_RECOVER;
            end
            ST_RECOVER: w_next = ST_IDLE;
            ST_WAIT: begin
                // leave the cycle after the tick that hits 0
                if (r_wait == 16'd0)
                    w_next = ST_IDLE;
                else if (w_tick && r_wait == 16'd1)
                    w_next = ST_IDLE;
            end
            ST_HALT:    w_next = ST_HALT;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready    = 1'b0;
        out_wr     = 1'b0;
        out_busy   = 1'b1;
        out_halted = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_ready  = !in_rst;
                out_busy = 1'b0;
            end
            ST_STROBE: out_wr     = 1'b1;
            ST_HALT:   out_halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_reg  <= 4'd0;
            r_val  <= 8'd0;
            r_hold <= 4'd0;
            r_wait <= 16'd0;
        end else begin
            if (w_acc && w_op == OP_WRITE) begin
                r_reg <= cmd.in_cmd_arg[11:8];
                r_val <= cmd.in_cmd_arg[7:0];
            end
            if (r_state == ST_SETUP)
                r_hold <= HOLD_LD;
            else if (r_state == ST_STROBE && r_hold != 4'd0)
                r_hold <= r_hold - 4'd1;
            if (w_acc && w_op == OP_WAIT)
                r_wait <= cmd.in_cmd_arg;
            else if (r_state == ST_WAIT && w_tick && r_wait != 16'd0)
                r_wait <= r_wait - 16'd1;
        end
    end

    assign cmd.out_cmd_ready = w_ready;
    assign out_reg  = r_reg;
    assign out_val  = r_val;
    assign out_tick = w_tick;

endmodule
